// File: rtl/hood_pkg.sv
// hood_pkg: 3-bit hood state codes shared by the mode FSM, mode LED decoder and fan driver.
package hood_pkg;
  typedef enum logic [2:0] {
    ST_OFF          = 3'b000,
    ST_STANDBY      = 3'b001,
    ST_MODE_SELECT  = 3'b010,
    ST_FIRST_LEVEL  = 3'b011,
    ST_SECOND_LEVEL = 3'b100,
    ST_THIRD_LEVEL  = 3'b101,
    ST_CLEAN        = 3'b110,
    ST_ILLEGAL      = 3'b111
  } hood_state_e;
endpackage

// File: rtl/hood_sec_timer.sv
// hood_sec_timer: seconds countdown with load, tick decrement, expire strobe and clear.
module hood_sec_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic [TW-1:0] remain,
  output logic          expire
);
  always_ff @(posedge clk or posedge rst)
    if (rst) remain <= '0;
    else if (clear) remain <= '0;
    else if (load) remain <= load_val;
    else if (tick && remain != '0) remain <= remain - 1'b1;
  assign expire = tick && remain == TW'(1);
endmodule

// File: rtl/hood_mode_fsm.sv
// hood_mode_fsm: range-hood mode FSM with timed third-level burst and self-clean countdown.
// Define HOOD_THIRD_ONCE_EN to allow third level only once per power-on session.
module hood_mode_fsm
  import hood_pkg::*;
#(
  parameter int THIRD_S = 60,
  parameter int CLEAN_S = 180,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_1hz,
  input  logic          btn_power,
  input  logic          btn_menu,
  input  logic          btn_lvl1,
  input  logic          btn_lvl2,
  input  logic          btn_lvl3,
  input  logic          btn_clean,
  output logic [2:0]    state,
  output logic [TW-1:0] remain_s,
  output logic          clean_done
);
  hood_state_e cur, nxt;
  logic permit, expire, timed;
  assign timed = cur == ST_THIRD_LEVEL || cur == ST_CLEAN;
  always_comb begin
    nxt = cur;
    if (cur != ST_OFF && btn_power) nxt = ST_OFF;
    else case (cur)
      ST_OFF:         nxt = btn_power ? ST_STANDBY : ST_OFF;
      ST_STANDBY:     nxt = btn_menu ? ST_MODE_SELECT : cur;
      ST_MODE_SELECT: nxt = btn_menu ? ST_STANDBY :
                            btn_clean ? ST_CLEAN :
                            (btn_lvl3 && permit) ? ST_THIRD_LEVEL :
                            btn_lvl2 ? ST_SECOND_LEVEL :
                            btn_lvl1 ? ST_FIRST_LEVEL : cur;
      ST_FIRST_LEVEL,
      ST_SECOND_LEVEL: nxt = btn_menu ? ST_STANDBY :
                            (btn_lvl3 && permit) ? ST_THIRD_LEVEL :
                            btn_lvl2 ? ST_SECOND_LEVEL :
                            btn_lvl1 ? ST_FIRST_LEVEL : cur;
      ST_THIRD_LEVEL: nxt = expire ? ST_SECOND_LEVEL : cur;
      ST_CLEAN:       nxt = expire ? ST_STANDBY : cur;
      default:        nxt = ST_OFF;
    endcase
  end
`ifdef HOOD_THIRD_ONCE_EN
  logic third_used;
  always_ff @(posedge clk or posedge rst)
    if (rst) third_used <= 1'b0;
    else if (nxt == ST_OFF) third_used <= 1'b0;
    else if (nxt == ST_THIRD_LEVEL) third_used <= 1'b1;
  assign permit = !third_used;
`else
  assign permit = 1'b1;
`endif
  // Tick only counts while already in a timed state, so the entry cycle never decrements.
  hood_sec_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (nxt == ST_OFF),
    .load     (nxt != cur && (nxt == ST_THIRD_LEVEL || nxt == ST_CLEAN)),
    .load_val (nxt == ST_CLEAN ? TW'(CLEAN_S) : TW'(THIRD_S)),
    .tick     (tick_1hz && timed),
    .remain   (remain_s),
    .expire   (expire)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur        <= ST_OFF;
      clean_done <= 1'b0;
    end else begin
      cur        <= nxt;
      clean_done <= cur == ST_CLEAN && nxt == ST_STANDBY;
    end
  assign state = cur;
endmodule

// File: tb/tb_hood_mode_fsm.sv
// tb_hood_mode_fsm: vector table, corner sequences and randomized run against a behavioural model.
module tb_hood_mode_fsm;
  localparam int THIRD_S = 3;
  localparam int CLEAN_S = 4;
  localparam int TW = 8;
  localparam logic [6:0] P = 7'b1000000, M = 7'b0100000, C = 7'b0010000,
                         L3 = 7'b0001000, L2 = 7'b0000100, L1 = 7'b0000010, T = 7'b0000001;
  logic clk = 0, rst = 1;
  logic tick_1hz = 0, btn_power = 0, btn_menu = 0, btn_lvl1 = 0, btn_lvl2 = 0, btn_lvl3 = 0, btn_clean = 0;
  logic [2:0] state;
  logic [TW-1:0] remain_s;
  logic clean_done;
  int total = 0, bad = 0;
  hood_mode_fsm #(.THIRD_S(THIRD_S), .CLEAN_S(CLEAN_S), .TW(TW)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_power(btn_power), .btn_menu(btn_menu),
    .btn_lvl1(btn_lvl1), .btn_lvl2(btn_lvl2), .btn_lvl3(btn_lvl3), .btn_clean(btn_clean),
    .state(state), .remain_s(remain_s), .clean_done(clean_done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [6:0]    b;
    logic [2:0]    st;
    logic [TW-1:0] rem;
    logic          done;
  } vec_t;
  vec_t vt[$];
  int m_st, m_rem;
  bit m_done, m_used;
  task automatic add(input logic [6:0] b, input logic [2:0] st, input int rem, input logic done);
    vec_t v;
    v.b = b; v.st = st; v.rem = TW'(rem); v.done = done;
    vt.push_back(v);
  endtask
  task automatic apply(input logic [6:0] b);
    @(negedge clk);
    {btn_power, btn_menu, btn_clean, btn_lvl3, btn_lvl2, btn_lvl1, tick_1hz} = b;
    @(posedge clk);
    #1;
    {btn_power, btn_menu, btn_clean, btn_lvl3, btn_lvl2, btn_lvl1, tick_1hz} = '0;
  endtask
  task automatic check(input string nm, input logic [2:0] st, input logic [TW-1:0] rem, input logic done);
    total += 3;
    if (state !== st) begin bad++; $display("FAIL %s state got=%0d want=%0d", nm, state, st); end
    if (remain_s !== rem) begin bad++; $display("FAIL %s remain_s got=%0d want=%0d", nm, remain_s, rem); end
    if (clean_done !== done) begin bad++; $display("FAIL %s clean_done got=%0b want=%0b", nm, clean_done, done); end
  endtask
  task automatic step(input string nm, input logic [6:0] b, input int st, input int rem, input logic done);
    apply(b);
    check(nm, 3'(st), TW'(rem), done);
  endtask
  // Reference: codes 0..6 = OFF,STANDBY,MENU,L1,L2,L3,CLEAN with a plain seconds counter.
  function automatic void model(input logic [6:0] b);
    bit p, me, cl, l3, l2, l1, tk, ok3;
    {p, me, cl, l3, l2, l1, tk} = b;
`ifdef HOOD_THIRD_ONCE_EN
    ok3 = !m_used;
`else
    ok3 = 1;
`endif
    m_done = 0;
    if (m_st == 0) begin
      if (p) m_st = 1;
    end else if (p) begin
      m_st = 0; m_rem = 0; m_used = 0;
    end else if (m_st == 1) begin
      if (me) m_st = 2;
    end else if (m_st == 2 || m_st == 3 || m_st == 4) begin
      if (me) m_st = m_st == 2 ? 2 - 1 : 1;
      else if (cl && m_st == 2) begin m_st = 6; m_rem = CLEAN_S; end
      else if (l3 && ok3) begin m_st = 5; m_rem = THIRD_S; m_used = 1; end
      else if (l2) m_st = 4;
      else if (l1) m_st = 3;
    end else if (tk) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_done = m_st == 6;
        m_st = m_st == 6 ? 1 : 4;
      end
    end
  endfunction
  initial begin
    add(P, 1, 0, 0); add(M, 2, 0, 0); add(L2, 4, 0, 0);
    add(L3, 5, 3, 0); add(T, 5, 2, 0); add(T, 5, 1, 0); add(T, 4, 0, 0); add(0, 4, 0, 0);
    add(P, 0, 0, 0); add(P, 1, 0, 0); add(M, 2, 0, 0); add(C, 6, 4, 0);
    add(T, 6, 3, 0); add(T, 6, 2, 0); add(T, 6, 1, 0); add(T, 1, 0, 1); add(0, 1, 0, 0);
    add(M, 2, 0, 0); add(C, 6, 4, 0); add(P | T, 0, 0, 0);
    add(P, 1, 0, 0); add(M, 2, 0, 0); add(L1, 3, 0, 0); add(M | L2, 1, 0, 0);
    add(M, 2, 0, 0); add(L3 | T, 5, 3, 0); add(M, 5, 3, 0); add(L1, 5, 3, 0);
    add(T, 5, 2, 0); add(C, 5, 2, 0); add(P | T, 0, 0, 0);
    add(M, 0, 0, 0); add(L3, 0, 0, 0); add(P, 1, 0, 0); add(M, 2, 0, 0);
    add(C | L3, 6, 4, 0); add(M | T, 6, 3, 0); add(P, 0, 0, 0);
    add(P, 1, 0, 0); add(M, 2, 0, 0); add(L1, 3, 0, 0); add(L3 | L2, 5, 3, 0); add(P, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset", 3'd0, '0, 1'b0);
    rst = 0;
    foreach (vt[i]) begin
      apply(vt[i].b);
      check($sformatf("vec%0d", i), vt[i].st, vt[i].rem, vt[i].done);
    end
    step("ar_pw", P, 1, 0, 0); step("ar_mn", M, 2, 0, 0);
    step("ar_cl", C, 6, 4, 0); step("ar_tk", T, 6, 3, 0);
    #2 rst = 1;
    #1 check("async_rst", 3'd0, '0, 1'b0);
    @(negedge clk) rst = 0;
    step("ar_after", T, 0, 0, 0);
`ifdef HOOD_THIRD_ONCE_EN
    step("o_pw", P, 1, 0, 0); step("o_mn", M, 2, 0, 0); step("o_l3", L3, 5, 3, 0);
    step("o_t1", T, 5, 2, 0); step("o_t2", T, 5, 1, 0); step("o_t3", T, 4, 0, 0);
    step("o_l3blk", L3, 4, 0, 0); step("o_mn2", M, 1, 0, 0); step("o_mn3", M, 2, 0, 0);
    step("o_l3blk2", L3, 2, 0, 0); step("o_off", P, 0, 0, 0); step("o_on", P, 1, 0, 0);
    step("o_mn4", M, 2, 0, 0); step("o_l3ok", L3, 5, 3, 0);
`endif
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    m_st = 0; m_rem = 0; m_used = 0; m_done = 0;
    for (int n = 0; n < 800; n++) begin
      logic [6:0] b;
      b = {$urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0};
      apply(b);
      model(b);
      check($sformatf("rnd%0d", n), 3'(m_st), TW'(m_rem), m_done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
